// File: rtl/aes_job_sequencer.sv
// AES job sequencer: collects a 128-bit plaintext operand over a simple
// register bus and hands it to an external AES engine. It also captures the
// engine result and exposes it as read-once ciphertext words.
module aes_job_sequencer (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         we_i,
  input  logic [8:0]   address_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  rdata_o,
  input  logic [3:0]   reglk_ctrl_i,
  output logic         eng_start_o,
  output logic [127:0] eng_pt_o,
  input  logic         eng_done_i,
  input  logic [127:0] eng_ct_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  localparam logic [5:0] ADDR_CTRL   = 6'd5;
  localparam logic [5:0] ADDR_STATUS = 6'd6;
  localparam logic [5:0] ADDR_CT3    = 6'd7;
  localparam logic [5:0] ADDR_CT2    = 6'd8;
  localparam logic [5:0] ADDR_CT1    = 6'd9;
  localparam logic [5:0] ADDR_CT0    = 6'd10;
  localparam logic [7:0] TMO_LAST    = 8'd254;

  state_e            state_q, state_d;
  logic [3:0][31:0]  pt_q, pt_d;
  logic [3:0]        mask_q, mask_d;
  logic [127:0]      ct_q, ct_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [5:0] addr;
  logic [1:0] pt_idx;
  logic       wr, rd, is_pt, is_ctrl;
  logic [2:0] unused_addr_lo;

  assign addr           = address_i[8:3];
  assign unused_addr_lo = address_i[2:0];
  assign wr             = en_i && we_i;
  assign rd             = en_i && !we_i;
  assign is_pt          = (addr >= 6'd1) && (addr <= 6'd4);
  assign is_ctrl        = (addr == ADDR_CTRL);
  // Addresses 1..4 map to words 3..0: ~(a-1) on the low two bits gives 3,2,1,0.
  assign pt_idx         = ~(addr[1:0] - 2'd1);

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pt_q    <= '0;
      mask_q  <= '0;
      ct_q    <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      mask_q  <= mask_d;
      ct_q    <= ct_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic for the job FSM, operand/result registers and bus reads.
  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    mask_d  = mask_q;
    ct_d    = ct_q;
    tmo_d   = tmo_q;
    done_d  = done_q;
    err_d   = err_q;
    rdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr && is_pt && !reglk_ctrl_i[pt_idx]) begin
          pt_d[pt_idx]   = wdata_i;
          mask_d[pt_idx] = 1'b1;
        end
        if (wr && is_ctrl && wdata_i[0]) begin
          if (mask_q == 4'hF) begin
            state_d = ST_START;
            err_d   = 1'b0;
            done_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // Engine completion takes priority over a simultaneous abort.
        if (eng_done_i) begin
          ct_d    = eng_ct_i;
          done_d  = 1'b1;
          state_d = ST_CLEAR;
        end else if (wr && is_ctrl && wdata_i[1]) begin
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = tmo_q + 8'd1;
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_CLEAR: begin
        pt_d    = '0;
        mask_d  = '0;
        tmo_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd) begin
      unique case (addr)
        ADDR_STATUS: rdata_d = {29'b0, err_q, done_q, busy_o};
        ADDR_CT3:    rdata_d = done_q ? ct_q[127:96] : '0;
        ADDR_CT2:    rdata_d = done_q ? ct_q[95:64]  : '0;
        ADDR_CT1:    rdata_d = done_q ? ct_q[63:32]  : '0;
        ADDR_CT0:    rdata_d = done_q ? ct_q[31:0]   : '0;
        default:     rdata_d = '0;
      endcase
      // Reading the last ct word consumes the result.
      if (addr == ADDR_CT0 && done_q) begin
        ct_d   = '0;
        done_d = 1'b0;
      end
    end
  end

  assign eng_start_o = (state_q == ST_START);
  assign busy_o      = (state_q != ST_IDLE);
  assign eng_pt_o    = (state_q == ST_START || state_q == ST_WAIT) ? pt_q : '0;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Self-checking bench for aes_job_sequencer: bus reads go through a
// scoreboard queue, address-map reads come from a vector table, and the
// multi-cycle scenarios are hand-written sequences.
module tb_aes_job_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, we;
  logic [8:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata_o;
  logic [3:0]   reglk;
  logic         eng_start_o;
  logic [127:0] eng_pt_o;
  logic         eng_done;
  logic [127:0] eng_ct;
  logic         busy_o, done_o, err_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [5:0]  a;
    logic [31:0] exp;
    string       name;
  } rd_vec_t;
  rd_vec_t tbl[9];

  aes_job_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .we_i         (we),
    .address_i    (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata_o),
    .reglk_ctrl_i (reglk),
    .eng_start_o  (eng_start_o),
    .eng_pt_o     (eng_pt_o),
    .eng_done_i   (eng_done),
    .eng_ct_i     (eng_ct),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every read request sampled at a clock edge pops one entry.
  always @(posedge clk) begin
    if (rst_n && en && !we) begin
      sb_t e;
      #1;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got read with no expectation want queued entry");
      end else begin
        e = sb_q.pop_front();
        chk(e.name, {96'b0, rdata_o}, {96'b0, e.exp});
      end
    end
  end

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    en    = 1'b1;
    we    = 1'b1;
    addr  = {a, 3'($urandom_range(0, 7))};
    wdata = d;
    tick();
    en    = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    en   = 1'b1;
    we   = 1'b0;
    addr = {a, 3'($urandom_range(0, 7))};
    tick();
    en   = 1'b0;
    addr = '0;
  endtask

  task automatic load_pt(input logic [127:0] pt);
    for (int i = 0; i < 4; i++) begin
      bus_write(6'(i + 1), pt[127 - 32*i -: 32]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, {127'b0, eng_start_o}, 128'd0);
    chk({tag, "_pt"},    eng_pt_o, 128'd0);
    chk({tag, "_busy"},  {127'b0, busy_o}, 128'd0);
    chk({tag, "_done"},  {127'b0, done_o}, 128'd0);
    chk({tag, "_err"},   {127'b0, err_o}, 128'd0);
    chk({tag, "_rdata"}, {96'b0, rdata_o}, 128'd0);
  endtask

  initial begin
    logic [127:0] pt1, ct1, pt2, ct2, pt3;
    logic [31:0]  w0;
    int           n;

    pt1 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    ct1 = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    pt3 = {$urandom, $urandom, $urandom, $urandom};

    // Address-map reads after the normal job has completed (done=1, err=0, idle).
    tbl[0] = '{6'd0,  32'h0,        "map_a0"};
    tbl[1] = '{6'd1,  32'h0,        "map_pt3_hidden"};
    tbl[2] = '{6'd2,  32'h0,        "map_pt2_hidden"};
    tbl[3] = '{6'd3,  32'h0,        "map_pt1_hidden"};
    tbl[4] = '{6'd4,  32'h0,        "map_pt0_hidden"};
    tbl[5] = '{6'd5,  32'h0,        "map_ctrl_wo"};
    tbl[6] = '{6'd6,  32'h2,        "map_status_done"};
    tbl[7] = '{6'd11, 32'h0,        "map_a11"};
    tbl[8] = '{6'd63, 32'h0,        "map_a63"};

    en = 0; we = 0; addr = '0; wdata = '0; reglk = '0; eng_done = 0; eng_ct = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    // A done pulse right after reset release must be ignored.
    eng_done = 1'b1;
    eng_ct   = ct1;
    tick();
    eng_done = 1'b0;
    eng_ct   = '0;
    chk("post_reset_done_ignored", {127'b0, done_o}, 128'd0);
    chk("post_reset_idle", {127'b0, busy_o}, 128'd0);

    // Normal job.
    load_pt(pt1);
    bus_write(6'd5, 32'h1);
    chk("job1_start_pulse", {127'b0, eng_start_o}, 128'd1);
    chk("job1_busy", {127'b0, busy_o}, 128'd1);
    chk("job1_pt_out", eng_pt_o, pt1);
    tick();
    chk("job1_start_one_cycle", {127'b0, eng_start_o}, 128'd0);
    chk("job1_pt_wait", eng_pt_o, pt1);
    tick();
    tick();
    eng_done = 1'b1;
    eng_ct   = ct1;
    tick();
    eng_done = 1'b0;
    eng_ct   = '0;
    chk("job1_done", {127'b0, done_o}, 128'd1);
    chk("job1_err", {127'b0, err_o}, 128'd0);
    chk("job1_clear_busy", {127'b0, busy_o}, 128'd1);
    chk("job1_pt_cleared", eng_pt_o, 128'd0);
    tick();
    chk("job1_idle", {127'b0, busy_o}, 128'd0);

    for (int i = 0; i < 9; i++) begin
      bus_read(tbl[i].a, tbl[i].exp, tbl[i].name);
    end
    tick();
    chk("rdata_idle_zero", {96'b0, rdata_o}, 128'd0);

    bus_read(6'd7, ct1[127:96], "job1_ct3");
    bus_read(6'd8, ct1[95:64],  "job1_ct2");
    bus_read(6'd9, ct1[63:32],  "job1_ct1");
    chk("job1_done_held", {127'b0, done_o}, 128'd1);
    bus_read(6'd10, ct1[31:0],  "job1_ct0_readclear");
    chk("readclear_done", {127'b0, done_o}, 128'd0);
    for (int i = 7; i <= 10; i++) begin
      bus_read(6'(i), 32'h0, "reread_ct_zero");
    end
    bus_read(6'd6, 32'h0, "status_after_readclear");

    // Locked word 0: mask stays incomplete, start is refused.
    reglk = 4'b0001;
    load_pt(pt2);
    bus_write(6'd5, 32'h1);
    chk("lock_err", {127'b0, err_o}, 128'd1);
    chk("lock_no_start", {127'b0, eng_start_o}, 128'd0);
    chk("lock_idle", {127'b0, busy_o}, 128'd0);
    tick();
    chk("lock_no_start_later", {127'b0, eng_start_o}, 128'd0);
    bus_read(6'd6, 32'h4, "lock_status");

    // Unlock, supply word 0, and start: err clears; engine then never answers.
    reglk = 4'b0000;
    w0 = $urandom;
    bus_write(6'd4, w0);
    bus_write(6'd5, 32'h1);
    chk("tmo_start", {127'b0, eng_start_o}, 128'd1);
    chk("tmo_err_cleared", {127'b0, err_o}, 128'd0);
    chk("tmo_pt_out", eng_pt_o, {pt2[127:32], w0});
    n = 0;
    while (!err_o && n < 300) begin
      tick();
      n++;
    end
    // One edge START->WAIT, then 255 cycles in WAIT.
    chk("tmo_cycles", 128'(n), 128'd256);
    chk("tmo_no_done", {127'b0, done_o}, 128'd0);
    chk("tmo_clear_busy", {127'b0, busy_o}, 128'd1);
    chk("tmo_pt_cleared", eng_pt_o, 128'd0);
    tick();
    bus_read(6'd7, 32'h0, "tmo_ct3_zero");
    bus_read(6'd10, 32'h0, "tmo_ct0_zero");
    bus_write(6'd5, 32'h1);
    chk("tmo_mask_cleared_nostart", {127'b0, eng_start_o}, 128'd0);

    // Plain abort.
    load_pt(pt3);
    bus_write(6'd5, 32'h1);
    chk("abort_start", {127'b0, eng_start_o}, 128'd1);
    tick();
    tick();
    bus_write(6'd5, 32'h2);
    chk("abort_err", {127'b0, err_o}, 128'd1);
    chk("abort_no_done", {127'b0, done_o}, 128'd0);
    chk("abort_clear", {127'b0, busy_o}, 128'd1);
    tick();

    // Abort and engine completion in the same WAIT cycle: done wins.
    load_pt(pt2);
    bus_write(6'd5, 32'h1);
    chk("collide_err_cleared", {127'b0, err_o}, 128'd0);
    tick();
    en = 1'b1; we = 1'b1; addr = {6'd5, 3'd0}; wdata = 32'h2;
    eng_done = 1'b1; eng_ct = ct2;
    tick();
    en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    eng_done = 1'b0; eng_ct = '0;
    chk("collide_done", {127'b0, done_o}, 128'd1);
    chk("collide_err", {127'b0, err_o}, 128'd0);
    tick();
    bus_read(6'd7,  ct2[127:96], "collide_ct3");
    bus_read(6'd8,  ct2[95:64],  "collide_ct2");
    bus_read(6'd9,  ct2[63:32],  "collide_ct1");
    bus_read(6'd10, ct2[31:0],   "collide_ct0");

    // Reset while waiting on the engine.
    load_pt(pt1);
    bus_write(6'd5, 32'h1);
    tick();
    chk("midrst_in_wait", {127'b0, busy_o}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    eng_done = 1'b1;
    eng_ct   = ct1;
    tick();
    eng_done = 1'b0;
    eng_ct   = '0;
    chk("midrst_done_ignored", {127'b0, done_o}, 128'd0);
    bus_write(6'd5, 32'h1);
    chk("midrst_restart_err", {127'b0, err_o}, 128'd1);
    chk("midrst_restart_nostart", {127'b0, eng_start_o}, 128'd0);

    tick();
    tick();
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
